// File: rtl/output_capture_buffer_if.sv
// Bus bundle for the output capture buffer: capture-side inputs, drain-side
// ready/valid stream and run status. The DUT takes the slave view.
interface output_capture_buffer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 14
);
  logic                     start;
  logic signed [DATA_W-1:0] y_in;
  logic                     valid_in;
  logic                     rd_start;
  logic                     rd_ready;
  logic        [DATA_W-1:0] rd_data;
  logic                     rd_valid;
  logic                     rd_last;
  logic        [ADDR_W-1:0] wr_count;
  logic                     busy;
  logic                     full;
  logic                     overflow;
  logic        [DATA_W-1:0] peak_abs;

  modport master (
    output start, y_in, valid_in, rd_start, rd_ready,
    input  rd_data, rd_valid, rd_last, wr_count, busy, full, overflow, peak_abs
  );

  modport slave (
    input  start, y_in, valid_in, rd_start, rd_ready,
    output rd_data, rd_valid, rd_last, wr_count, busy, full, overflow, peak_abs
  );
endinterface

// File: rtl/output_capture_buffer.sv
// Captures NUM_SAMPLES signed filter outputs into a single-clock RAM, tracks
// the peak magnitude, then drains the run in address order over a
// ready/valid stream. The drain path is RAM read register -> skid -> output
// register, so the stream keeps one transfer per cycle despite the RAM's
// one-cycle read latency.
module output_capture_buffer #(
  parameter int NUM_SAMPLES = 5500,
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 14
) (
  input logic                   clk,
  input logic                   rst_n,
  output_capture_buffer_if.slave bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;
  localparam logic [1:0] ST_DRAIN   = 2'd3;

  localparam logic [ADDR_W-1:0] N_CNT     = ADDR_W'(NUM_SAMPLES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SAMPLES - 1);
  localparam logic [DATA_W-1:0] MAX_POS   = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_NEG   = {1'b1, {(DATA_W-1){1'b0}}};

  logic [1:0]        state, state_next;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic [ADDR_W-1:0] wr_count;
  logic [ADDR_W-1:0] rd_ptr;
  logic              busy, full, overflow;
  logic [DATA_W-1:0] peak_abs, abs_in, y_bits;

  logic              q_valid, q_last, skid_valid, skid_last;
  logic [DATA_W-1:0] q_data, skid_data;
  logic              rd_valid, rd_last;
  logic [DATA_W-1:0] rd_data;

  logic wr_en, out_free, last_xfer, skid_empty_next, fetch;

  assign y_bits    = bus.y_in;
  assign wr_en     = (state == ST_CAPTURE) && bus.valid_in && !bus.start;
  assign out_free  = !rd_valid || bus.rd_ready;
  assign last_xfer = rd_valid && bus.rd_ready && rd_last;
  // A read may only be issued if the skid will be empty after this edge, so
  // the data it returns always has somewhere to go on the following edge.
  assign skid_empty_next = out_free ? !(skid_valid && q_valid)
                                    : !(skid_valid || q_valid);
  assign fetch = (state == ST_DRAIN) && !bus.start && (rd_ptr != N_CNT)
                 && skid_empty_next;

  // Magnitude of the incoming sample, saturating the most negative code.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    abs_in = y_bits;
    if (y_bits[DATA_W-1]) abs_in = (y_bits == MIN_NEG) ? MAX_POS : (~y_bits + 1'b1);
  end

  // Next-state decode; start from any state (re)arms a fresh capture.
  always_comb begin
    state_next = state;
    if (bus.start) begin
      state_next = ST_CAPTURE;
    end else begin
      case (state)
        ST_CAPTURE: if (wr_en && (wr_count == LAST_ADDR)) state_next = ST_FULL;
        ST_FULL:    if (bus.rd_start) state_next = ST_DRAIN;
        ST_DRAIN:   if (last_xfer) state_next = ST_IDLE;
        default:    state_next = state;
      endcase
    end
  end

  // State register with registered status flags derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      full  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == ST_CAPTURE) || (state_next == ST_DRAIN);
      full  <= (state_next == ST_FULL);
    end
  end

  // Capture counters: write count, sticky overflow and running peak magnitude.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count <= '0;
      overflow <= 1'b0;
      peak_abs <= '0;
    end else if (bus.start) begin
      wr_count <= '0;
      overflow <= 1'b0;
      peak_abs <= '0;
    end else begin
      if (wr_en) begin
        wr_count <= wr_count + 1'b1;
        if (abs_in > peak_abs) peak_abs <= abs_in;
      end
      if ((state == ST_FULL) && bus.valid_in) overflow <= 1'b1;
    end
  end

  // Sample RAM write port.
  always_ff @(posedge clk) begin
    // NOTE: the RAM array has no reset; a run only ever reads addresses it has written.
    if (wr_en) mem[wr_count] <= bus.y_in;
  end

  // Drain pipeline: synchronous RAM read, skid register and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      q_valid    <= 1'b0;
      q_last     <= 1'b0;
      q_data     <= '0;
      skid_valid <= 1'b0;
      skid_last  <= 1'b0;
      skid_data  <= '0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
      rd_data    <= '0;
    end else if ((state != ST_DRAIN) || bus.start) begin
      rd_ptr     <= '0;
      q_valid    <= 1'b0;
      skid_valid <= 1'b0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
    end else begin
      q_valid <= fetch;
      if (fetch) begin
        q_data <= mem[rd_ptr];
        q_last <= (rd_ptr == LAST_ADDR);
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (out_free) begin
        if (skid_valid) begin
          rd_data    <= skid_data;
          rd_last    <= skid_last;
          rd_valid   <= 1'b1;
          skid_valid <= q_valid;
          skid_data  <= q_data;
          skid_last  <= q_last;
        end else if (q_valid) begin
          rd_data  <= q_data;
          rd_last  <= q_last;
          rd_valid <= 1'b1;
        end else begin
          rd_valid <= 1'b0;
          rd_last  <= 1'b0;
        end
      end else if (q_valid) begin
        skid_valid <= 1'b1;
        skid_data  <= q_data;
        skid_last  <= q_last;
      end
    end
  end

  assign bus.rd_data  = rd_data;
  assign bus.rd_valid = rd_valid;
  assign bus.rd_last  = rd_last;
  assign bus.wr_count = wr_count;
  assign bus.busy     = busy;
  assign bus.full     = full;
  assign bus.overflow = overflow;
  assign bus.peak_abs = peak_abs;

endmodule

// File: tb/tb_output_capture_buffer.sv
// Directed bench for output_capture_buffer with NUM_SAMPLES=8. Captured
// samples are queued as expected drain data and popped on each transfer.
module tb_output_capture_buffer;
  localparam int N  = 8;
  localparam int DW = 16;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  logic [DW-1:0] exp_q[$];
  int exp_count = 0;
  int exp_peak = 0;
  bit exp_capturing = 1'b0;

  output_capture_buffer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  output_capture_buffer #(.NUM_SAMPLES(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    exp_count = 0;
    exp_peak = 0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    model_clear();
    exp_capturing = 1'b1;
  endtask

  task automatic feed(input int v, input int gap);
    int a;
    bus.y_in = 16'(v);
    bus.valid_in = 1'b1;
    tick(1);
    bus.valid_in = 1'b0;
    if (exp_capturing) begin
      a = (v < 0) ? -v : v;
      if (a > 32767) a = 32767;
      if (a > exp_peak) exp_peak = a;
      exp_q.push_back(16'(v));
      exp_count++;
      if (exp_count == N) exp_capturing = 1'b0;
    end
    if (gap > 0) tick(gap);
  endtask

  // mode 0: ready held high, 1: ready pattern 1,0,0,1 repeating, 2: random.
  task automatic drain(input int mode, input int max_xfers);
    int n;
    int cyc;
    bit ready;
    bit stalled;
    logic [DW-1:0] e;
    n = 0;
    cyc = 0;
    stalled = 1'b0;
    bus.rd_start = 1'b1;
    tick(1);
    bus.rd_start = 1'b0;
    check("drain_busy", 32'(bus.busy), 1);
    check("lat_edge1", 32'(bus.rd_valid), 0);
    tick(1);
    check("lat_edge2", 32'(bus.rd_valid), 0);
    tick(1);
    check("lat_first_valid", 32'(bus.rd_valid), 1);
    while (n < max_xfers && exp_q.size() > 0 && cyc < 100) begin
      if (stalled) begin
        check("stall_valid", 32'(bus.rd_valid), 1);
        check("stall_data", 32'(bus.rd_data), 32'(exp_q[0]));
        check("stall_last", 32'(bus.rd_last), 32'(exp_q.size() == 1));
      end
      case (mode)
        0: ready = 1'b1;
        1: ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: ready = 1'($urandom_range(0, 1));
      endcase
      bus.rd_ready = ready;
      if (mode == 0) check("stream_valid", 32'(bus.rd_valid), 1);
      if (bus.rd_valid && ready) begin
        e = exp_q.pop_front();
        check("rd_data", 32'(bus.rd_data), 32'(e));
        check("rd_last", 32'(bus.rd_last), 32'(exp_q.size() == 0));
        n++;
      end
      stalled = bus.rd_valid && !ready;
      tick(1);
      cyc++;
    end
    bus.rd_ready = 1'b0;
    check("drain_progress", 32'((n == max_xfers) || (exp_q.size() == 0)), 1);
    if (exp_q.size() == 0) begin
      check("end_valid", 32'(bus.rd_valid), 0);
      check("end_idle_busy", 32'(bus.busy), 0);
      check("end_idle_full", 32'(bus.full), 0);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.y_in = '0;
    bus.valid_in = 1'b0;
    bus.rd_start = 1'b0;
    bus.rd_ready = 1'b0;
    #1;
    check("rst_rd_data", 32'(bus.rd_data), 0);
    check("rst_rd_valid", 32'(bus.rd_valid), 0);
    check("rst_rd_last", 32'(bus.rd_last), 0);
    check("rst_wr_count", 32'(bus.wr_count), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_full", 32'(bus.full), 0);
    check("rst_overflow", 32'(bus.overflow), 0);
    check("rst_peak", 32'(bus.peak_abs), 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // rd_start in IDLE is ignored.
    bus.rd_start = 1'b1;
    tick(1);
    bus.rd_start = 1'b0;
    tick(3);
    check("idle_rd_start_valid", 32'(bus.rd_valid), 0);
    check("idle_rd_start_busy", 32'(bus.busy), 0);

    // Capture 1..8 with gaps; rd_start mid-capture is ignored.
    do_start();
    check("cap_busy", 32'(bus.busy), 1);
    check("cap_count0", 32'(bus.wr_count), 0);
    for (int i = 1; i <= N; i++) begin
      feed(i, (i % 3) + 1);
      if (i == 3) begin
        bus.rd_start = 1'b1;
        tick(1);
        bus.rd_start = 1'b0;
        check("cap_rd_start_busy", 32'(bus.busy), 1);
        check("cap_rd_start_full", 32'(bus.full), 0);
      end
      if (i == N - 1) check("not_full_yet", 32'(bus.full), 0);
    end
    check("full_set", 32'(bus.full), 1);
    check("full_busy", 32'(bus.busy), 0);
    check("full_count", 32'(bus.wr_count), 32'(exp_count));
    check("full_overflow", 32'(bus.overflow), 0);
    check("full_peak", 32'(bus.peak_abs), 32'(exp_peak));

    // valid_in while FULL sets overflow and writes nothing.
    feed(999, 1);
    check("ovf_set", 32'(bus.overflow), 1);
    check("ovf_count", 32'(bus.wr_count), 32'(N));

    // Drain with ready held high.
    drain(0, N);
    check("kept_count", 32'(bus.wr_count), 32'(N));
    check("kept_peak", 32'(bus.peak_abs), 32'(exp_peak));

    // Peak saturation, then restart from within CAPTURE.
    do_start();
    check("restart_ovf_clr", 32'(bus.overflow), 0);
    feed(-32768, 0);
    feed(100, 1);
    feed(-5, 0);
    check("peak_sat", 32'(bus.peak_abs), 32'(exp_peak));
    do_start();
    check("recap_count0", 32'(bus.wr_count), 0);
    check("recap_peak0", 32'(bus.peak_abs), 0);
    feed(3, 0);
    feed(-7, 2);
    check("peak_small", 32'(bus.peak_abs), 32'(exp_peak));
    check("recap_count2", 32'(bus.wr_count), 2);
    for (int i = 0; i < N - 2; i++) feed(i * 11 - 30, i % 2);
    check("recap_full", 32'(bus.full), 1);
    drain(1, N);

    // Reset mid-drain after three transfers.
    do_start();
    for (int i = 0; i < N; i++) feed(500 - i * 37, 0);
    drain(0, 3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.rd_valid), 0);
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_count", 32'(bus.wr_count), 0);
    check("mid_rst_peak", 32'(bus.peak_abs), 0);
    #2;
    rst_n = 1'b1;
    model_clear();
    exp_capturing = 1'b0;
    tick(1);

    // Fresh capture, abort from FULL, capture again and drain with random ready.
    do_start();
    for (int i = 0; i < N; i++) feed(i * 1000 - 4000, 0);
    check("post_rst_full", 32'(bus.full), 1);
    do_start();
    check("abort_full", 32'(bus.full), 0);
    check("abort_busy", 32'(bus.busy), 1);
    check("abort_count", 32'(bus.wr_count), 0);
    for (int i = 0; i < N; i++) feed(i * 7 - 20, int'($urandom_range(0, 2)));
    check("final_full", 32'(bus.full), 1);
    drain(2, N);
    check("final_peak", 32'(bus.peak_abs), 32'(exp_peak));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/output_capture_buffer.md
OUTPUT_CAPTURE_BUFFER -- requirements
Module: output_capture_buffer

Interface
REQ-001 Parameter NUM_SAMPLES, default 5500, number of samples captured per run.
REQ-002 Parameter DATA_W, default 16, sample width, signed two's complement.
REQ-003 Parameter ADDR_W, default 14, RAM address and count width; the design SHALL support NUM_SAMPLES <= 2^ADDR_W - 1.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 start  in  1  single-cycle pulse that clears counters and arms a capture.
REQ-007 y_in  in  DATA_W  signed filter output sample.
REQ-008 valid_in  in  1  y_in is valid this cycle.
REQ-009 rd_start  in  1  pulse that begins in-order drain of the captured samples.
REQ-010 rd_ready  in  1  downstream accepts rd_data this cycle.
REQ-011 rd_data  out  DATA_W  drained sample.
REQ-012 rd_valid  out  1  rd_data holds a valid sample.
REQ-013 rd_last  out  1  rd_data is sample NUM_SAMPLES-1.
REQ-014 wr_count  out  ADDR_W  number of samples written in the current run.
REQ-015 busy  out  1  high in CAPTURE or DRAIN.
REQ-016 full  out  1  high in FULL.
REQ-017 overflow  out  1  sticky flag: valid_in seen while in FULL.
REQ-018 peak_abs  out  DATA_W  largest |y_in| captured in the current run.

Function
REQ-019 The FSM SHALL have states IDLE, CAPTURE, FULL and DRAIN.
REQ-020 IDLE->CAPTURE on start: wr_count, overflow and peak_abs SHALL be cleared in the same edge.
REQ-021 In CAPTURE, each cycle with valid_in=1 SHALL write y_in to RAM[wr_count] and increment wr_count; cycles with valid_in=0 SHALL write nothing.
REQ-022 The write that makes wr_count equal NUM_SAMPLES SHALL move the FSM to FULL on the same edge; valid_in in FULL SHALL NOT write and SHALL set overflow.
REQ-023 FULL->DRAIN on rd_start; rd_start in any other state SHALL be ignored.
REQ-024 start in FULL or DRAIN SHALL abort, re-clear and re-enter CAPTURE; start in CAPTURE SHALL restart the capture at address 0.
REQ-025 peak_abs SHALL update on every accepted write to max(peak_abs, |y_in|), with |-2^(DATA_W-1)| saturated to 2^(DATA_W-1)-1.
REQ-026 The RAM SHALL be single-clock with synchronous read (1-cycle latency).
REQ-027 In DRAIN, the first rd_valid SHALL assert exactly 2 cycles after the rd_start edge, with rd_data = RAM[0].
REQ-028 A transfer occurs when rd_valid=1 and rd_ready=1; the samples SHALL be presented in address order 0..NUM_SAMPLES-1.
REQ-029 While rd_valid=1 and rd_ready=0, rd_data, rd_valid and rd_last SHALL hold stable.
REQ-030 With rd_ready held high, the block SHALL sustain one transfer per cycle after the first, using a skid register as needed.
REQ-031 After the transfer with rd_last=1, the block SHALL deassert rd_valid on the next edge and return to IDLE; wr_count and peak_abs SHALL be retained until the next start.
REQ-032 busy SHALL be registered and SHALL reflect the current state.
REQ-033 The pointer arithmetic SHALL never wrap past NUM_SAMPLES-1.

Reset
REQ-034 On rst_n=0, the block SHALL asynchronously enter IDLE and drive rd_data=0, rd_valid=0, rd_last=0, wr_count=0, busy=0, full=0, overflow=0 and peak_abs=0.
REQ-035 Reset mid-CAPTURE or mid-DRAIN SHALL discard the run; RAM contents need not be cleared.
REQ-036 The first start accepted after rst_n rises SHALL behave per REQ-020.

Verification
REQ-037 NUM_SAMPLES=8: start, then 8 valid samples 1..8 with gaps -> full=1 after the 8th; wr_count=8; overflow=0.
REQ-038 After REQ-037: rd_start with rd_ready=1 -> rd_valid 2 cycles later; 8 consecutive transfers 1..8; rd_last only on value 8; then IDLE.
REQ-039 Drain with rd_ready toggling 1,0,0,1,... -> no sample lost or duplicated; outputs stable during stalls.
REQ-040 Samples -32768, 100, -5 -> peak_abs=32767; samples 3, -7 -> peak_abs=7.
REQ-041 valid_in pulse in FULL -> overflow=1, RAM unchanged; next start -> overflow=0.
REQ-042 rst_n low during DRAIN after 3 transfers -> rd_valid=0 immediately, IDLE; a fresh start and capture operate normally.
